// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake plus framed serial output of the serializer
interface piso_serializer_if #(parameter int WIDTH = 6);
  logic [WIDTH-1:0] par_in;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             frame_start;
  logic             done;
  modport master (output par_in, load_valid, input load_ready, so, so_valid, frame_start, done);
  modport slave  (input par_in, load_valid, output load_ready, so, so_valid, frame_start, done);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, one bit per clock out with first/last strobes
module piso_serializer #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  piso_serializer_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             shifting, last, accept;
  assign shifting   = state_q == SHIFT;
  assign last       = shifting && cnt_q == '0;
  assign accept     = bus.load_valid && bus.load_ready;
  assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
  always_comb begin
    state_d = accept ? SHIFT : last ? IDLE : state_q;
    sr_d    = accept ? bus.par_in : shifting ? sr_shifted : sr_q;
    cnt_d   = accept ? CW'(WIDTH - 1) : (shifting && !last) ? cnt_q - 1'b1 : cnt_q;
    first_d = accept;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end
  // reset gates ready directly so it drops the moment reset asserts, not at the next edge
  assign bus.load_ready  = reset && (!shifting || last);
  assign bus.so_valid    = shifting;
  assign bus.so          = shifting && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
  assign bus.frame_start = shifting && first_q;
  assign bus.done        = last;
endmodule
